// File: rtl/button_command_encoder.sv
// button_command_encoder
//
// Input front-end for the game core. Each of the five raw push-buttons goes
// through a 2-FF synchronizer, a debounce filter, a rising-edge detector and
// a one-deep pending flag. A fixed-priority arbiter then hands pending presses
// to the game FSM one at a time over a valid/ack handshake.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronized cycles needed to accept a
//                    level change (>= 2)
//   REPEAT_CYCLES    hold time between auto-repeat commands (auto-repeat only)
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   btnLeft      raw button, active-high, asynchronous
//   btnRight     raw button, active-high, asynchronous
//   btnUp        raw button, active-high, asynchronous
//   btnDown      raw button, active-high, asynchronous
//   btnSelect    raw button, active-high, asynchronous
//   cmd_ack      game core accepts the presented command this cycle
//   cmd_valid    a command is presented
//   cmd_code     0=none 1=left 2=right 3=up 4=down 5=select
//   btn_level    debounced levels {select,down,up,right,left}
//   cmd_overrun  sticky: a press was dropped because its flag was still set
//
// Build option:
//   BTN_AUTOREPEAT_EN  when defined, holding left/right/up/down re-arms the
//                      pending flag every REPEAT_CYCLES; select never repeats.

module button_command_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnSelect,
    input  logic       cmd_ack,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [4:0] btn_level,
    output logic       cmd_overrun
);

    localparam int unsigned MaxCycles = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ?
                                        DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W     = $clog2(MaxCycles + 1);
    localparam int          NumBtn    = 5;

    typedef enum logic [0:0] {StIdle, StPresent} arbStateT;

    // Bit order matches btn_level and cmd_code-1.
    logic [4:0] rawBtn;
    logic [4:0] syncMeta;
    logic [4:0] syncBtn;
    logic [4:0] debLevel;
    logic [4:0] levelPrev;
    logic [4:0] rise;
    logic [4:0] repeatSet;
    logic [4:0] pendingQ;
    logic [4:0] pendingD;
    logic       overrunQ;
    logic       overrunD;
    logic [4:0] clearMask;
    logic [4:0] pickMask;
    logic [2:0] pickCode;
    logic [2:0] codeQ;
    logic [2:0] codeD;
    arbStateT   stateQ;
    arbStateT   stateD;

    assign rawBtn = {btnSelect, btnDown, btnUp, btnRight, btnLeft};

    // Two-flop synchronizer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncMeta <= '0;
            syncBtn  <= '0;
        end else begin
            syncMeta <= rawBtn;
            syncBtn  <= syncMeta;
        end
    end

    // Debounce: count consecutive cycles the synchronized input disagrees with
    // the accepted level; any agreement restarts the count.
    for (genvar b = 0; b < NumBtn; b++) begin : gDebounce
        logic [CNT_W-1:0] cnt;
        logic             level;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (syncBtn[b] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign debLevel[b] = level;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            levelPrev <= '0;
        end else begin
            levelPrev <= debLevel;
        end
    end

    assign rise = debLevel & ~levelPrev;

`ifdef BTN_AUTOREPEAT_EN
    // Repeat timer only runs while the button is held and its previous
    // command has already been taken by the arbiter.
    for (genvar b = 0; b < 4; b++) begin : gRepeat
        logic [CNT_W-1:0] rptCnt;
        logic             running;
        logic             expire;

        assign running      = debLevel[b] & ~pendingQ[b];
        assign expire       = running && (rptCnt == CNT_W'(REPEAT_CYCLES - 1));
        assign repeatSet[b] = expire;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rptCnt <= '0;
            end else if (!running || expire) begin
                rptCnt <= '0;
            end else begin
                rptCnt <= rptCnt + CNT_W'(1);
            end
        end
    end
    assign repeatSet[4] = 1'b0;
`else
    assign repeatSet = '0;
`endif

    // Fixed priority: select > up > down > left > right
    always_comb begin
        pickMask = '0;
        pickCode = 3'd0;
        if (pendingQ[4]) begin
            pickMask = 5'b10000;
            pickCode = 3'd5;
        end else if (pendingQ[2]) begin
            pickMask = 5'b00100;
            pickCode = 3'd3;
        end else if (pendingQ[3]) begin
            pickMask = 5'b01000;
            pickCode = 3'd4;
        end else if (pendingQ[0]) begin
            pickMask = 5'b00001;
            pickCode = 3'd1;
        end else if (pendingQ[1]) begin
            pickMask = 5'b00010;
            pickCode = 3'd2;
        end
    end

    always_comb begin
        stateD    = stateQ;
        codeD     = codeQ;
        clearMask = '0;
        unique case (stateQ)
            StIdle: begin
                if (|pendingQ) begin
                    stateD    = StPresent;
                    codeD     = pickCode;
                    clearMask = pickMask;
                end
            end
            StPresent: begin
                if (cmd_ack) begin
                    stateD = StIdle;
                    codeD  = 3'd0;
                end
            end
            default: begin
                stateD = StIdle;
                codeD  = 3'd0;
            end
        endcase
    end

    // A rise landing on the same edge its flag is handed to the arbiter simply
    // re-arms the flag; only a rise onto a flag that stays set is a drop.
    always_comb begin
        pendingD = (pendingQ & ~clearMask) | rise | repeatSet;
        overrunD = overrunQ | (|(rise & pendingQ & ~clearMask));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ   <= StIdle;
            codeQ    <= 3'd0;
            pendingQ <= '0;
            overrunQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            codeQ    <= codeD;
            pendingQ <= pendingD;
            overrunQ <= overrunD;
        end
    end

    assign cmd_valid   = (stateQ == StPresent);
    assign cmd_code    = codeQ;
    assign btn_level   = debLevel;
    assign cmd_overrun = overrunQ;

endmodule

// File: tb/tb_button_command_encoder.sv
// Self-checking bench for button_command_encoder (DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=16). A behavioural model tracks the expected outputs and is
// compared every cycle; directed scenarios add hand-computed literal checks.
// Inputs change on the falling edge; "edge N" means the N-th rising edge after
// the stimulus change.

module tb_button_command_encoder;

    localparam int DEB = 4;
    localparam int REP = 16;
    localparam int PRIO [5] = '{4, 2, 3, 0, 1};

    logic       clk;
    logic       rst;
    logic [4:0] raw;
    logic       ack;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [4:0] btn_level;
    logic       cmd_overrun;

    int checks;
    int errors;
    int dutCmds;
    logic prevValid;
    logic checkEn;

    button_command_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btnLeft    (raw[0]),
        .btnRight   (raw[1]),
        .btnUp      (raw[2]),
        .btnDown    (raw[3]),
        .btnSelect  (raw[4]),
        .cmd_ack    (ack),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .btn_level  (btn_level),
        .cmd_overrun(cmd_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0]     mS1, mS2, mLvl, mLvlPrev, mPend, mFlip, mRise, mClr, mRep, mPendN;
    logic           mOver, mOverN;
    int             mCode, mNextCode;
    logic [DEB-1:0] mHist [5];
    logic [DEB-1:0] mHistN [5];
`ifdef BTN_AUTOREPEAT_EN
    int             mRpt [4];
    int             mRptN [4];
`endif

    always_comb begin
        // A level flips once the last DEB synchronized samples all disagree with it.
        for (int b = 0; b < 5; b++) begin
            mHistN[b] = {mHist[b][DEB-2:0], mS2[b]};
            mFlip[b]  = (mHistN[b] == {DEB{~mLvl[b]}});
        end
        mRise     = mLvl & ~mLvlPrev;
        mClr      = '0;
        mNextCode = mCode;
        if (mCode == 0) begin
            for (int k = 0; k < 5; k++) begin
                if (mClr == '0 && mPend[PRIO[k]]) begin
                    mClr[PRIO[k]] = 1'b1;
                    mNextCode     = PRIO[k] + 1;
                end
            end
        end else if (ack) begin
            mNextCode = 0;
        end
        mRep = '0;
`ifdef BTN_AUTOREPEAT_EN
        for (int b = 0; b < 4; b++) begin
            mRptN[b] = 0;
            if (mLvl[b] && !mPend[b]) begin
                mRptN[b] = mRpt[b] + 1;
                if (mRptN[b] == REP) begin
                    mRep[b]  = 1'b1;
                    mRptN[b] = 0;
                end
            end
        end
`endif
        mPendN = (mPend & ~mClr) | mRise | mRep;
        mOverN = mOver | (|(mRise & mPend & ~mClr));
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mS1      <= '0;
            mS2      <= '0;
            mLvl     <= '0;
            mLvlPrev <= '0;
            mPend    <= '0;
            mOver    <= 1'b0;
            mCode    <= 0;
            for (int b = 0; b < 5; b++) mHist[b] <= '0;
`ifdef BTN_AUTOREPEAT_EN
            for (int b = 0; b < 4; b++) mRpt[b] <= 0;
`endif
        end else begin
            mS1      <= raw;
            mS2      <= mS1;
            for (int b = 0; b < 5; b++) mHist[b] <= mHistN[b];
            mLvl     <= mLvl ^ mFlip;
            mLvlPrev <= mLvl;
            mPend    <= mPendN;
            mOver    <= mOverN;
            mCode    <= mNextCode;
`ifdef BTN_AUTOREPEAT_EN
            for (int b = 0; b < 4; b++) mRpt[b] <= mRptN[b];
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        prevValid = 1'b0;
        dutCmds   = 0;
        forever begin
            @(negedge clk);
            if (checkEn) begin
                chk("model cmd_valid", int'(cmd_valid), int'(mCode != 0));
                chk("model cmd_code", int'(cmd_code), mCode);
                chk("model btn_level", int'(btn_level), int'(mLvl));
                chk("model cmd_overrun", int'(cmd_overrun), int'(mOver));
                if (cmd_valid && !prevValid) dutCmds++;
                prevValid = cmd_valid;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int base;
        checks  = 0;
        errors  = 0;
        checkEn = 1'b0;
        rst     = 1'b0;
        raw     = '0;
        ack     = 1'b1;
        tick(2);
        checkEn = 1'b1;

        // Reset with every button held
        raw = 5'b11111;
        tick(3);
        chk("reset cmd_valid", int'(cmd_valid), 0);
        chk("reset cmd_code", int'(cmd_code), 0);
        chk("reset btn_level", int'(btn_level), 0);
        chk("reset cmd_overrun", int'(cmd_overrun), 0);
        rst = 1'b1;
        tick(5);
        chk("reset level edge5", int'(btn_level), 0);
        tick(1);
        chk("reset level edge6", int'(btn_level), 31);
        tick(1);
        chk("reset valid edge7", int'(cmd_valid), 0);
        tick(1);
        chk("reset valid edge8", int'(cmd_valid), 1);
        chk("reset code edge8", int'(cmd_code), 5);
        tick(2);
        chk("reset code edge10", int'(cmd_code), 3);
        raw = '0;
        tick(30);

        // Single press of down
        base = dutCmds;
        raw[3] = 1'b1;
        tick(7);
        chk("single valid edge7", int'(cmd_valid), 0);
        tick(1);
        chk("single valid edge8", int'(cmd_valid), 1);
        chk("single code edge8", int'(cmd_code), 4);
        tick(1);
        chk("single valid edge9", int'(cmd_valid), 0);
        tick(11);
        raw[3] = 1'b0;
        tick(30);
`ifdef BTN_AUTOREPEAT_EN
        chk("single cmd count", dutCmds - base, 2);
`else
        chk("single cmd count", dutCmds - base, 1);
`endif

        // Glitch on right shorter than the debounce window
        raw[1] = 1'b1;
        tick(3);
        raw[1] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            chk("glitch level", int'(btn_level[1]), 0);
            chk("glitch valid", int'(cmd_valid), 0);
        end
        tick(10);

        // Priority and handshake: left + up together, ack held off
        ack    = 1'b0;
        raw[0] = 1'b1;
        raw[2] = 1'b1;
        tick(6);
        raw[0] = 1'b0;
        raw[2] = 1'b0;
        tick(2);
        for (int i = 0; i < 10; i++) begin
            chk("prio hold valid", int'(cmd_valid), 1);
            chk("prio hold code", int'(cmd_code), 3);
            if (i < 9) tick(1);
        end
        ack = 1'b1;
        tick(1);
        chk("prio idle gap", int'(cmd_valid), 0);
        tick(1);
        chk("prio second valid", int'(cmd_valid), 1);
        chk("prio second code", int'(cmd_code), 1);
        tick(1);
        chk("prio second done", int'(cmd_valid), 0);
        tick(20);

        // Overrun: three left presses while the first is still unacknowledged
        ack  = 1'b0;
        base = dutCmds;
        for (int p = 0; p < 3; p++) begin
            raw[0] = 1'b1;
            tick(6);
            raw[0] = 1'b0;
            if (p < 2) tick(6);
        end
        tick(3);
        chk("overrun flag", int'(cmd_overrun), 1);
        chk("overrun valid", int'(cmd_valid), 1);
        chk("overrun code", int'(cmd_code), 1);
        ack = 1'b1;
        tick(20);
        chk("overrun cmd count", dutCmds - base, 2);
        chk("overrun sticky", int'(cmd_overrun), 1);

`ifdef BTN_AUTOREPEAT_EN
        // Auto-repeat on right, none on select
        base   = dutCmds;
        raw[1] = 1'b1;
        tick(68);
        raw[1] = 1'b0;
        tick(30);
        chk("repeat right count", dutCmds - base, 4);
        base   = dutCmds;
        raw[4] = 1'b1;
        tick(60);
        raw[4] = 1'b0;
        tick(30);
        chk("repeat select count", dutCmds - base, 1);
`endif

        // Reset mid-handshake drops the command and clears the sticky flag
        ack    = 1'b0;
        raw[2] = 1'b1;
        tick(8);
        chk("midreset valid before", int'(cmd_valid), 1);
        #2;
        rst    = 1'b0;
        raw[2] = 1'b0;
        tick(2);
        chk("midreset valid", int'(cmd_valid), 0);
        chk("midreset overrun", int'(cmd_overrun), 0);
        rst = 1'b1;
        base = dutCmds;
        tick(20);
        chk("midreset no command", dutCmds - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
